// File: rtl/ifetch_unit_if.sv
// ---------------------------------------------------------------------------
// ifetch_unit_if
//   Bundles every non-clock signal of the instruction fetch stage.
//
//   Instruction memory side
//     imem_req     fetch -> mem  request valid; accepted in the cycle it is high
//     imem_addr    fetch -> mem  byte address of the requested word
//     imem_rvalid  mem -> fetch  one-cycle response pulse per request
//     imem_rdata   mem -> fetch  instruction word, meaningful with imem_rvalid
//   Redirect side (from execute / branch resolution)
//     redirect_valid  one-cycle pulse: flush and refetch from redirect_pc
//     redirect_pc     new fetch address
//   Decode side
//     instr_valid  fetch -> dec  FIFO head valid
//     instr        fetch -> dec  FIFO head instruction
//     instr_pc     fetch -> dec  PC of instr
//     id_ready     dec -> fetch  decode consumes the head this cycle
//     halted       fetch -> dec  HALT fetched, fetch stopped
//
//   Handshake rules:
//     - Memory: imem_req has no ready; the request is taken in every cycle it
//       is high. Exactly one imem_rvalid pulse answers each request, at least
//       one cycle later. The fetch unit keeps at most one request open.
//     - Decode: a word moves when instr_valid && id_ready at a rising edge.
//       instr/instr_pc are stable while instr_valid is high and not consumed,
//       except that a redirect flushes the queue regardless of id_ready.
//
//   Modports: master = fetch unit, slave = memory/decode environment.
// ---------------------------------------------------------------------------
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        id_ready;
  logic        halted;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    output instr,
    output instr_pc,
    input  id_ready,
    output halted
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output id_ready,
    input  halted
  );
endinterface

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//   Instruction fetch stage in front of the decoder. Owns the PC, keeps one
//   word read open toward instruction memory, buffers returned words in a
//   QDEPTH-entry FIFO and hands them to decode with valid/ready. Folds
//   unconditional B branches locally, takes redirects from later stages and
//   stops fetching after a HALT word.
//
//   Parameters
//     RESET_PC  PC loaded at reset (byte address, word aligned)
//     QDEPTH    FIFO entries, power of two, >= 2
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     bus        ifetch_unit_if.master (memory, redirect and decode signals)
//     dbg_state  current FSM state (FETCH=0, WAIT=1, HALTED=2)
// ---------------------------------------------------------------------------
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  ifetch_unit_if.master bus,
  output logic [1:0]    dbg_state
);

  localparam int                PW      = $clog2(QDEPTH);
  localparam int                CNT_W   = PW + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(QDEPTH);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       fifo_instr_q [QDEPTH];
  logic [31:0]       fifo_instr_d [QDEPTH];
  logic [31:0]       fifo_pc_q    [QDEPTH];
  logic [31:0]       fifo_pc_d    [QDEPTH];

  // -------------------------------------------------------------------------
  // Predecode of the word currently returning from memory
  // -------------------------------------------------------------------------
  logic        is_b;
  logic        is_halt;
  logic [31:0] br_off;

  assign is_b    = (bus.imem_rdata[31:25] == 7'b1100000);
  assign is_halt = (bus.imem_rdata[31:30] == 2'b11) && bus.imem_rdata[28]
                   && !bus.imem_rdata[27];
  // Word offset: sign-extended imm[15:0] scaled to bytes.
  assign br_off  = {{14{bus.imem_rdata[15]}}, bus.imem_rdata[15:0], 2'b00};

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  logic issue;
  logic push;
  logic pop;
  logic flush;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    issue        = 1'b0;
    push         = 1'b0;
    flush        = 1'b0;

    if (bus.redirect_valid) begin
      // Redirect wins over everything. A response landing in this same
      // cycle belongs to the old path and is simply not pushed.
      flush = 1'b1;
      pc_d  = {bus.redirect_pc[31:2], 2'b00};
      if ((state_q == ST_WAIT) && !bus.imem_rvalid) begin
        // Old-path response still in flight: remember to swallow it.
        state_d = ST_WAIT;
        drop_d  = 1'b1;
      end else begin
        state_d = ST_FETCH;
        drop_d  = 1'b0;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          // No request is open in FETCH, so the FIFO count alone is the
          // occupancy including reservations. rst_n gating keeps imem_req
          // low while reset is held.
          if (rst_n && (count_q < DEPTH_C)) begin
            issue   = 1'b1;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rvalid) begin
            if (drop_q) begin
              // Stale response from before a redirect; pc already points
              // at the new path.
              drop_d  = 1'b0;
              state_d = ST_FETCH;
            end else begin
              push = 1'b1;
              if (is_b) begin
                pc_d = pc_q + br_off;
              end else begin
                pc_d = pc_q + 32'd4;
              end
              state_d = is_halt ? ST_HALTED : ST_FETCH;
            end
          end
        end
        ST_HALTED: begin
          // Only a redirect (above) or reset leaves this state.
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end

    pop = !flush && (count_q != '0) && bus.id_ready;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // The issue rule reserves a slot before every request, so a push
      // always has room (or meets a simultaneous pop).
      if (push) begin
        fifo_instr_d[wr_ptr_q] = bus.imem_rdata;
        fifo_pc_d[wr_ptr_q]    = pc_q;
        wr_ptr_d               = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      drop_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.imem_req    = issue;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr       = fifo_instr_q[rd_ptr_q];
  assign bus.instr_pc    = fifo_pc_q[rd_ptr_q];
  assign bus.halted      = (state_q == ST_HALTED);
  assign dbg_state       = state_q;

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Owns the PC and issues word reads to instruction memory (one outstanding request).
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
- Folds unconditional branches (B) itself, accepts redirects (Bcond/BR resolution) from later stages, and stops on HALT.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset; byte address, word aligned.
- QDEPTH, 2, instruction FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  request valid; accepted on the same cycle it is high.
- imem_addr  out  32  byte address of requested word.
- imem_rvalid  in  1  response valid; one pulse per request, latency ≥1 cycle.
- imem_rdata  in  32  instruction word; meaningful when imem_rvalid=1.
- redirect_valid  in  1  one-cycle pulse: flush and refetch.
- redirect_pc  in  32  new PC; meaningful when redirect_valid=1.
- instr_valid  out  1  FIFO head valid toward decode.
- instr  out  32  FIFO head instruction.
- instr_pc  out  32  PC of instr.
- id_ready  in  1  decode consumes head when instr_valid && id_ready.
- halted  out  1  HALT fetched; fetch stopped.

Behaviour:
- Reset values: pc=RESET_PC; FIFO empty; instr_valid=0; imem_req=0; halted=0; drop flag=0; state=FETCH; instr and instr_pc are 0.
- FSM states:
  - FETCH: may issue a request.
  - WAIT: one request is outstanding.
  - HALTED.
- Issue rule (FETCH): drive imem_req=1 and imem_addr=pc when FIFO occupancy < QDEPTH, counting the slot reserved for the outstanding response; then go to WAIT.
- Otherwise in FETCH, imem_req=0 and remain in FETCH.
- At most one request is outstanding at any time.
- WAIT, on imem_rvalid with drop=0:
  - Push {imem_rdata, pc}; pc += 4 (wraps modulo 2^32); go to FETCH.
  - The pushed word is visible at instr_valid the next cycle; minimum request-to-decode latency is 2 cycles.
- Predecode of the word being pushed (bits [31:25]):
  - 7'b1100000 (unconditional B): word is still pushed; pc ← pc_of_word + (sign-extended imm[15:0] << 2). No redirect is needed downstream.
  - [31:30]=2'b11 with [28]=1 and [27]=0 (HALT): word is pushed; go to HALTED; halted=1 from the next cycle.
  - NOP and all other words: sequential.
- Redirect (any state, highest priority):
  - FIFO is flushed in the same edge; instr_valid=0 the next cycle.
  - pc ← redirect_pc; HALTED exits to FETCH; halted=0.
  - If a request is outstanding (WAIT) and its response has not arrived this cycle, set drop=1 and stay in WAIT.
  - A response with drop=1 is discarded and clears drop. The state then returns to FETCH, without a pc increment.
  - A response arriving in the same cycle as a redirect is discarded.
- No request is issued in the redirect cycle.
- FIFO:
  - Simultaneous push and pop on a full FIFO is legal: occupancy is unchanged and ordering is preserved.
  - Pop on empty is ignored.
  - Wrap-around uses log2(QDEPTH)-bit pointers plus a count.
- HALTED:
  - imem_req=0; the FIFO continues to drain to decode.
  - Only reset or redirect leaves this state.
- Asynchronous reset mid-request discards any outstanding response. A stale imem_rvalid in the first cycle after reset is ignored, because state is FETCH.
- Misaligned redirect_pc: bits [1:0] are forced to 0.

Test Plan:
- Sequential fetch, 1-cycle memory, id_ready=1:
  - Words at 0x0, 0x4, 0x8 reach instr with instr_pc 0x0, 0x4, 0x8.
  - First instr_valid appears 2 cycles after reset release; pc increments by 4.
- Back-pressure:
  - id_ready=0 for 10 cycles → exactly QDEPTH words are buffered and imem_req stays 0.
  - id_ready=1 → words are delivered in order with no loss or duplication.
- Folded B:
  - Word 0xC000_0003 at 0x10 → word delivered with instr_pc=0x10; next imem_addr=0x1C.
  - Imm 0xFFFF at 0x10 → next imem_addr=0x0C.
- Redirect during WAIT with 3-cycle memory latency:
  - redirect_pc=0x200 → in-flight response is dropped and FIFO flushed.
  - Next imem_addr=0x200, and no instruction from the old path reaches decode.
- HALT:
  - Word 0xD000_0000 at 0x8 → delivered; halted=1; imem_req stays 0 for ≥20 cycles.
  - Then redirect to 0x40 → halted=0 and fetch resumes at 0x40.
- Async reset asserted while a request is outstanding:
  - All outputs return to reset values immediately.
  - A stale imem_rvalid after release is ignored; first request goes to RESET_PC.
